// File: rtl/register_bank_pc_pkg.sv
// Shared constants for the register bank, the bus-1 source multiplexer and the control unit.
package register_bank_pc_pkg;

    localparam int WORD_SIZE   = 8;
    localparam int NUM_GP_REGS = 4;

    // Bus-1 multiplexer channel assignments for the bank's outputs
    localparam logic [2:0] SEL_R0 = 3'd0;
    localparam logic [2:0] SEL_R1 = 3'd1;
    localparam logic [2:0] SEL_R2 = 3'd2;
    localparam logic [2:0] SEL_R3 = 3'd3;
    localparam logic [2:0] SEL_PC = 3'd4;

endpackage

// File: rtl/register_bank_pc_data_register.sv
// Generic word register with load enable and asynchronous active-low clear.
module data_register
    import register_bank_pc_pkg::*;
#(
    parameter int width = WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] r_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/register_bank_pc.sv
// General-purpose registers R0-R3 and the program counter, with wrap pulse and sticky load-conflict flag.
module register_bank_pc
    import register_bank_pc_pkg::*;
#(
    parameter int word_size = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [word_size-1:0] bus_2,
    input  logic                 load_r0,
    input  logic                 load_r1,
    input  logic                 load_r2,
    input  logic                 load_r3,
    input  logic                 load_pc,
    input  logic                 inc_pc,
    input  logic                 clr_err,
    output logic [word_size-1:0] r0_out,
    output logic [word_size-1:0] r1_out,
    output logic [word_size-1:0] r2_out,
    output logic [word_size-1:0] r3_out,
    output logic [word_size-1:0] pc_out,
    output logic                 pc_wrap,
    output logic                 load_conflict
);

    logic [NUM_GP_REGS-1:0] w_load_req;
    logic [NUM_GP_REGS-1:0] w_load_en;
    logic                   w_conflict;
    logic                   w_conflict_next;
    logic [word_size-1:0]   w_regs [NUM_GP_REGS];

    logic [word_size-1:0]   r_pc;
    logic                   r_pc_wrap;
    logic                   r_load_conflict;

    assign w_load_req = {load_r3, load_r2, load_r1, load_r0};
    assign w_conflict = ($countones(w_load_req) > 1);
    // A conflicting request is dropped entirely rather than partially applied
    assign w_load_en  = w_conflict ? '0 : w_load_req;

    for (genvar i = 0; i < NUM_GP_REGS; i++) begin : g_gp_reg
        data_register #(.width(word_size)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (w_load_en[i]),
            .d     (bus_2),
            .q     (w_regs[i])
        );
    end

    // NOTE: the hold value is assigned first so no path leaves the signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_conflict_next = r_load_conflict;
        if (w_conflict) begin
            w_conflict_next = 1'b1;
        end else if (clr_err) begin
            w_conflict_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= '0;
            r_pc_wrap       <= 1'b0;
            r_load_conflict <= 1'b0;
        end else begin
            r_pc_wrap       <= 1'b0;
            r_load_conflict <= w_conflict_next;
            if (load_pc) begin
                r_pc <= bus_2;
            end else if (inc_pc) begin
                r_pc      <= r_pc + word_size'(1);
                r_pc_wrap <= &r_pc;
            end
        end
    end

    assign r0_out        = w_regs[SEL_R0];
    assign r1_out        = w_regs[SEL_R1];
    assign r2_out        = w_regs[SEL_R2];
    assign r3_out        = w_regs[SEL_R3];
    assign pc_out        = r_pc;
    assign pc_wrap       = r_pc_wrap;
    assign load_conflict = r_load_conflict;

endmodule

// File: tb/tb_register_bank_pc.sv
// Scoreboard bench for register_bank_pc: stimulus queues expected snapshots, a monitor compares them.
module tb_register_bank_pc;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic [7:0] pc;
        logic       wrap;
        logic       conf;
    } snap_t;

    localparam logic [6:0] E_R0  = 7'b0000001;
    localparam logic [6:0] E_R1  = 7'b0000010;
    localparam logic [6:0] E_R2  = 7'b0000100;
    localparam logic [6:0] E_R3  = 7'b0001000;
    localparam logic [6:0] E_PC  = 7'b0010000;
    localparam logic [6:0] E_INC = 7'b0100000;
    localparam logic [6:0] E_CLR = 7'b1000000;
    localparam logic [6:0] E_NONE = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_2 = '0;
    logic       load_r0 = 1'b0, load_r1 = 1'b0, load_r2 = 1'b0, load_r3 = 1'b0;
    logic       load_pc = 1'b0, inc_pc = 1'b0, clr_err = 1'b0;
    logic [7:0] r0_out, r1_out, r2_out, r3_out, pc_out;
    logic       pc_wrap, load_conflict;

    int checks = 0;
    int errors = 0;

    snap_t exp_q [$];
    string name_q [$];

    always #5 clk = ~clk;

    register_bank_pc #(.word_size(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_2         (bus_2),
        .load_r0       (load_r0),
        .load_r1       (load_r1),
        .load_r2       (load_r2),
        .load_r3       (load_r3),
        .load_pc       (load_pc),
        .inc_pc        (inc_pc),
        .clr_err       (clr_err),
        .r0_out        (r0_out),
        .r1_out        (r1_out),
        .r2_out        (r2_out),
        .r3_out        (r3_out),
        .pc_out        (pc_out),
        .pc_wrap       (pc_wrap),
        .load_conflict (load_conflict)
    );

    function automatic snap_t mk(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                 input logic [7:0] r3, input logic [7:0] pc, input logic wrap,
                                 input logic conf);
        mk = '{r0: r0, r1: r1, r2: r2, r3: r3, pc: pc, wrap: wrap, conf: conf};
    endfunction

    function automatic snap_t sample();
        sample = '{r0: r0_out, r1: r1_out, r2: r2_out, r3: r3_out, pc: pc_out,
                   wrap: pc_wrap, conf: load_conflict};
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual r0=%h r1=%h r2=%h r3=%h pc=%h wrap=%b conf=%b required r0=%h r1=%h r2=%h r3=%h pc=%h wrap=%b conf=%b",
                     name, act.r0, act.r1, act.r2, act.r3, act.pc, act.wrap, act.conf,
                     req.r0, req.r1, req.r2, req.r3, req.pc, req.wrap, req.conf);
        end
    endtask

    task automatic drive(input logic [6:0] en, input logic [7:0] bus);
        bus_2   = bus;
        load_r0 = en[0];
        load_r1 = en[1];
        load_r2 = en[2];
        load_r3 = en[3];
        load_pc = en[4];
        inc_pc  = en[5];
        clr_err = en[6];
    endtask

    // Apply one cycle of stimulus and queue the outputs expected after that edge
    task automatic step(input string name, input logic [6:0] en, input logic [7:0] bus, input snap_t req);
        @(negedge clk);
        drive(en, bus);
        @(posedge clk);
        exp_q.push_back(req);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                check(name_q.pop_front(), sample(), exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout actual still running required finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        drive(E_NONE, 8'h00);
        repeat (2) @(posedge clk);
        #1 check("reset_initial", sample(), mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        step("load_r2",        E_R2,  8'h3C, mk(8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0));
        step("load_r0",        E_R0,  8'hA5, mk(8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0));
        step("load_r1",        E_R1,  8'h01, mk(8'hA5, 8'h01, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0));
        step("load_r3",        E_R3,  8'hFF, mk(8'hA5, 8'h01, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0));
        step("idle_hold",      E_NONE, 8'h99, mk(8'hA5, 8'h01, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0));
        step("preset_r1",      E_R1,  8'h11, mk(8'hA5, 8'h11, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0));
        step("preset_r3",      E_R3,  8'h33, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h00, 1'b0, 1'b0));
        step("conflict_r1_r3", E_R1 | E_R3, 8'h77, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h00, 1'b0, 1'b1));
        step("conflict_clr",   E_R0 | E_R2 | E_CLR, 8'h99, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h00, 1'b0, 1'b1));
        step("clr_err",        E_CLR, 8'h00, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h00, 1'b0, 1'b0));
        step("load_pc_fe",     E_PC,  8'hFE, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'hFE, 1'b0, 1'b0));
        step("inc_to_ff",      E_INC, 8'h00, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'hFF, 1'b0, 1'b0));
        step("inc_wrap",       E_INC, 8'h00, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h00, 1'b1, 1'b0));
        step("inc_after_wrap", E_INC, 8'h00, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h01, 1'b0, 1'b0));
        step("idle_no_wrap",   E_NONE, 8'h00, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h01, 1'b0, 1'b0));
        step("load_pc_10",     E_PC,  8'h10, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h10, 1'b0, 1'b0));
        step("pc_priority",    E_PC | E_INC, 8'h80, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h80, 1'b0, 1'b0));
        step("conflict_inc",   E_R1 | E_R2 | E_INC, 8'h44, mk(8'hA5, 8'h11, 8'h3C, 8'h33, 8'h81, 1'b0, 1'b1));
        step("shared_load",    E_PC | E_R0, 8'h5A, mk(8'h5A, 8'h11, 8'h3C, 8'h33, 8'h5A, 1'b0, 1'b1));
        step("load_pc_ff",     E_PC,  8'hFF, mk(8'h5A, 8'h11, 8'h3C, 8'h33, 8'hFF, 1'b0, 1'b1));
        step("load_beats_wrap", E_PC | E_INC, 8'h07, mk(8'h5A, 8'h11, 8'h3C, 8'h33, 8'h07, 1'b0, 1'b1));
        step("clr_err_2",      E_CLR, 8'h00, mk(8'h5A, 8'h11, 8'h3C, 8'h33, 8'h07, 1'b0, 1'b0));

        // Asynchronous reset in mid-cycle with a load and increment pending
        @(negedge clk);
        drive(E_R0 | E_INC, 8'hEE);
        #2 rst_n = 1'b0;
        #1 check("reset_async", sample(), mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1 check("reset_held", sample(), mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        drive(E_NONE, 8'h00);
        rst_n = 1'b1;
        step("post_reset_idle", E_NONE, 8'h00, mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        step("post_reset_r3",  E_R3,  8'hC3, mk(8'h00, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank_pc.md
Name: register_bank_pc

Overview:
- Holds the four general-purpose data registers R0–R3 and the program counter (PC).
- Its five word outputs drive the five data inputs of the 5-channel bus-1 source multiplexer: R0→channel 0, R1→1, R2→2, R3→3, PC→4.
- Loads come from bus 2 under control-unit enables.
- PC supports increment with wrap detection.
- Illegal multi-register load requests are flagged with a sticky error.

Parameters:
- word_size, 8, width of every register, the bus-2 input and all data outputs.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- bus_2  input  word_size  load data for all registers
- load_r0  input  1  load R0 from bus_2
- load_r1  input  1  load R1 from bus_2
- load_r2  input  1  load R2 from bus_2
- load_r3  input  1  load R3 from bus_2
- load_pc  input  1  load PC from bus_2
- inc_pc  input  1  PC <= PC + 1
- clr_err  input  1  clear load_conflict
- r0_out  output  word_size  R0 contents, to mux channel 0
- r1_out  output  word_size  R1 contents, to mux channel 1
- r2_out  output  word_size  R2 contents, to mux channel 2
- r3_out  output  word_size  R3 contents, to mux channel 3
- pc_out  output  word_size  PC contents, to mux channel 4
- pc_wrap  output  1  one-cycle pulse after PC wraps from all-ones to 0
- load_conflict  output  1  sticky: more than one of load_r0..load_r3 was asserted in the same cycle

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0, all of r0_out..r3_out, pc_out, pc_wrap and load_conflict are 0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards any pending load or increment.
- Latency: every update is sampled at the rising edge and visible on outputs in the same cycle after that edge (1-cycle latency). Outputs are registers only; no combinational path from any input to any output.
- Register loads: exactly one of load_r0..load_r3 asserted → that register takes bus_2; all others hold.
- Conflict: two or more of load_r0..load_r3 asserted in the same cycle →
  - none of R0–R3 is updated;
  - load_conflict is set;
  - PC handling is unaffected.
- load_conflict behaviour:
  - stays 1 until a cycle with clr_err=1 and no new conflict;
  - conflict and clr_err in the same cycle → flag remains 1 (set wins).
- PC priority: load_pc > inc_pc > hold.
  - load_pc and inc_pc together → PC = bus_2; no increment, no wrap pulse.
- PC increment: modulo 2^word_size.
  - inc_pc with PC = all-ones → PC becomes 0, and pc_wrap=1 for exactly the following cycle.
  - pc_wrap is 0 in every other case.
- load_pc together with one load_rN is legal: both destinations take the same bus_2 value.
- No enables asserted → all state holds.
- X handling: enables are expected to be known. The bench checks outputs only when rst_n=1 and the enables are known.

Decomposition:
- Shared package:
  - default word_size;
  - bus-1 select encodings SEL_R0=3'd0, SEL_R1=3'd1, SEL_R2=3'd2, SEL_R3=3'd3, SEL_PC=3'd4 (shared with the multiplexer and the control unit);
  - a NUM_GP_REGS=4 constant.
- Sub-module data_register: parameterised word register with load enable and async active-low clear. Instantiated four times for R0–R3.
- PC, wrap and conflict logic stay in the top.

Test Plan:
- Reset: preload all registers, assert rst_n=0 mid-cycle → all outputs 0 before the next edge, and hold 0 through edges while reset is held.
- Single loads: bus_2=8'h3C with load_r2 for one cycle → r2_out=8'h3C next cycle, other registers unchanged. Repeat for R0, R1, R3 with 8'hA5, 8'h01, 8'hFF.
- Conflict: R1=8'h11, R3=8'h33, then load_r1+load_r3 with bus_2=8'h77 → R1/R3 unchanged, load_conflict=1.
  - clr_err with a new conflict the same cycle → flag stays 1.
  - clr_err alone → flag 0 next cycle.
- PC wrap: load_pc with bus_2=8'hFE, then inc_pc for 3 cycles → pc_out 8'hFF, 8'h00 with pc_wrap=1 for that cycle only, then 8'h01 with pc_wrap=0.
- Priority: PC=8'h10, load_pc+inc_pc with bus_2=8'h80 → pc_out=8'h80, pc_wrap=0.
- Shared load: load_pc+load_r0 with bus_2=8'h5A → pc_out=r0_out=8'h5A, load_conflict unchanged.
